// File: rtl/idct_vecrot_pipe.sv
`timescale 1ns/1ps
// idct_vecrot_pipe
// Vector-rotation front end placed between the DCT-domain sample source and
// the IFFT/FFT core. For each sample k it forms t = A - j*B (B forced to zero
// at k = 0), multiplies t by a twiddle read from an external coefficient ROM,
// then rounds, shifts and saturates the product. The pipeline has three stages
// and Avalon-ST backpressure. It also checks frame length and keeps a sticky
// per-frame overflow flag.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   sink_valid/ready/sop/eop        input beat handshake and framing
//   sink_real/imag                  A = D(k)
//   sink_real_rev/imag_rev          B = D(N-k)
//   fftpts_in, mode                 frame length N and IDCT(0)/DCT(1) mode, taken on sop
//   coeff_addr, coeff_rd_en         ROM request (address = k)
//   coeff_cos, coeff_sin            ROM data, valid one clock after coeff_rd_en
//   source_valid/ready/sop/eop      output beat handshake and framing
//   source_error                    00 ok, 01 length error, 10 sop inside frame
//   source_real/imag                rotated, rounded, saturated result
//   fftpts_out                      N latched for the current frame
//   overflow                        sticky saturation flag for the current frame
module idct_vecrot_pipe #(
    parameter int WDATAIN  = 24,
    parameter int WDATAOUT = 24,
    parameter int WCOEFF   = 18,
    parameter int SHIFT    = 16,
    parameter int WADDR    = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sink_valid,
    output logic                sink_ready,
    input  logic                sink_sop,
    input  logic                sink_eop,
    input  logic [WDATAIN-1:0]  sink_real,
    input  logic [WDATAIN-1:0]  sink_imag,
    input  logic [WDATAIN-1:0]  sink_real_rev,
    input  logic [WDATAIN-1:0]  sink_imag_rev,
    input  logic [11:0]         fftpts_in,
    input  logic                mode,
    output logic [WADDR-1:0]    coeff_addr,
    output logic                coeff_rd_en,
    input  logic [WCOEFF-1:0]   coeff_cos,
    input  logic [WCOEFF-1:0]   coeff_sin,
    output logic                source_valid,
    input  logic                source_ready,
    output logic                source_sop,
    output logic                source_eop,
    output logic [1:0]          source_error,
    output logic [WDATAOUT-1:0] source_real,
    output logic [WDATAOUT-1:0] source_imag,
    output logic [11:0]         fftpts_out,
    output logic                overflow
);

    localparam int TW = WDATAIN + 1;
    localparam int PW = WDATAIN + WCOEFF + 2;

    localparam logic signed [PW-1:0] ROUND   = PW'(64'd1 << (SHIFT - 1));
    localparam logic signed [PW-1:0] OUT_MAX = PW'((64'd1 << (WDATAOUT - 1)) - 64'd1);
    localparam logic signed [PW-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic {IDLE, RUN} frame_state_t;

    frame_state_t     state;
    logic [WADDR-1:0] k_cnt;
    logic [11:0]      n_latch;
    logic             mode_latch;

    logic adv;
    logic accept;

    // The whole pipeline moves only when the output register can hand off its beat.
    assign adv         = !source_valid || source_ready;
    assign sink_ready  = adv;
    assign accept      = sink_valid && adv;
    assign coeff_rd_en = accept;
    assign fftpts_out  = n_latch;

    // Classify the beat at the sink: its index, frame length, mode and error code.
    // A sop beat, or any beat arriving while idle, is numbered 0.
    logic [WADDR-1:0] k_beat;
    logic [11:0]      n_beat;
    logic             mode_beat;
    logic             is_last;
    logic [1:0]       err_beat;

    always_comb begin
        k_beat    = k_cnt;
        n_beat    = n_latch;
        mode_beat = mode_latch;
        if (sink_sop) begin
            k_beat    = '0;
            n_beat    = fftpts_in;
            mode_beat = mode;
        end else if (state == IDLE) begin
            k_beat = '0;
        end
        is_last  = (12'(k_beat) == n_beat - 12'd1);
        err_beat = 2'b00;
        if (sink_sop && state == RUN)
            err_beat = 2'b10;
        else if (!sink_sop && state == IDLE)
            err_beat = 2'b10;
        else if (sink_eop != is_last)
            err_beat = 2'b01;
    end

    assign coeff_addr = k_beat;

    // Frame tracking. A short frame (early eop) or a missing eop both return
    // the counter to 0. A stray beat while idle leaves the state untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k_cnt      <= '0;
            n_latch    <= '0;
            mode_latch <= 1'b0;
        end else if (accept) begin
            if (sink_sop) begin
                n_latch    <= fftpts_in;
                mode_latch <= mode;
            end
            if (!sink_sop && state == IDLE) begin
                state <= IDLE;
                k_cnt <= '0;
            end else if (sink_eop) begin
                state <= IDLE;
                k_cnt <= '0;
            end else if (is_last) begin
                state <= RUN;
                k_cnt <= '0;
            end else begin
                state <= RUN;
                k_cnt <= k_beat + WADDR'(1);
            end
        end
    end

    // Stage 1: register A and B. B is zeroed for the DC term.
    logic                      s1_valid, s1_sop, s1_eop, s1_mode;
    logic [1:0]                s1_err;
    logic signed [WDATAIN-1:0] s1_ar, s1_ai, s1_br, s1_bi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_mode  <= 1'b0;
            s1_err   <= 2'b00;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
        end else if (adv) begin
            s1_valid <= sink_valid;
            if (accept) begin
                s1_sop  <= sink_sop;
                s1_eop  <= sink_eop;
                s1_mode <= mode_beat;
                s1_err  <= err_beat;
                s1_ar   <= $signed(sink_real);
                s1_ai   <= $signed(sink_imag);
                s1_br   <= (k_beat == '0) ? '0 : $signed(sink_real_rev);
                s1_bi   <= (k_beat == '0) ? '0 : $signed(sink_imag_rev);
            end
        end
    end

    // The ROM answers one clock after each read, whether or not the pipe then
    // stalls. Keep a copy so a stalled stage-1 beat still sees its coefficients.
    logic                     rom_pending;
    logic signed [WCOEFF-1:0] cos_hold, sin_hold, cos_live, sin_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_pending <= 1'b0;
            cos_hold    <= '0;
            sin_hold    <= '0;
        end else begin
            rom_pending <= coeff_rd_en;
            if (rom_pending) begin
                cos_hold <= $signed(coeff_cos);
                sin_hold <= $signed(coeff_sin);
            end
        end
    end

    assign cos_live = rom_pending ? $signed(coeff_cos) : cos_hold;
    assign sin_live = rom_pending ? $signed(coeff_sin) : sin_hold;

    // Stage 2: t = (ar + bi) + j(ai - br), and the twiddle is captured.
    logic                     s2_valid, s2_sop, s2_eop, s2_mode;
    logic [1:0]               s2_err;
    logic signed [TW-1:0]     s2_tr, s2_ti;
    logic signed [WCOEFF-1:0] s2_cos, s2_sin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sop   <= 1'b0;
            s2_eop   <= 1'b0;
            s2_mode  <= 1'b0;
            s2_err   <= 2'b00;
            s2_tr    <= '0;
            s2_ti    <= '0;
            s2_cos   <= '0;
            s2_sin   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sop  <= s1_sop;
                s2_eop  <= s1_eop;
                s2_mode <= s1_mode;
                s2_err  <= s1_err;
                s2_tr   <= TW'(s1_ar) + TW'(s1_bi);
                s2_ti   <= TW'(s1_ai) - TW'(s1_br);
                s2_cos  <= cos_live;
                s2_sin  <= sin_live;
            end
        end
    end

    // Stage 3 arithmetic. DCT mode flips the sign of the sine products rather
    // than the sine itself, so the most negative sine code cannot overflow.
    logic signed [PW-1:0]       tr_x, ti_x, c_x, s_x;
    logic signed [PW-1:0]       p_rc, p_rs, p_ic, p_is;
    logic signed [PW-1:0]       sum_re, sum_im, sh_re, sh_im;
    logic [WDATAOUT-1:0]        sat_re, sat_im;
    logic                       clip_re, clip_im;

    assign tr_x   = PW'(s2_tr);
    assign ti_x   = PW'(s2_ti);
    assign c_x    = PW'(s2_cos);
    assign s_x    = PW'(s2_sin);
    assign p_rc   = tr_x * c_x;
    assign p_rs   = tr_x * s_x;
    assign p_ic   = ti_x * c_x;
    assign p_is   = ti_x * s_x;
    assign sum_re = s2_mode ? (p_rc + p_is) : (p_rc - p_is);
    assign sum_im = s2_mode ? (p_ic - p_rs) : (p_rs + p_ic);
    assign sh_re  = (sum_re + ROUND) >>> SHIFT;
    assign sh_im  = (sum_im + ROUND) >>> SHIFT;

    // Clamp each component independently to the output range.
    always_comb begin
        sat_re  = sh_re[WDATAOUT-1:0];
        sat_im  = sh_im[WDATAOUT-1:0];
        clip_re = 1'b0;
        clip_im = 1'b0;
        if (sh_re > OUT_MAX) begin
            sat_re  = OUT_MAX[WDATAOUT-1:0];
            clip_re = 1'b1;
        end else if (sh_re < OUT_MIN) begin
            sat_re  = OUT_MIN[WDATAOUT-1:0];
            clip_re = 1'b1;
        end
        if (sh_im > OUT_MAX) begin
            sat_im  = OUT_MAX[WDATAOUT-1:0];
            clip_im = 1'b1;
        end else if (sh_im < OUT_MIN) begin
            sat_im  = OUT_MIN[WDATAOUT-1:0];
            clip_im = 1'b1;
        end
    end

    // Output register. Overflow restarts with each sop beat, so it covers
    // exactly the frame that is currently leaving the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_error <= 2'b00;
            source_real  <= '0;
            source_imag  <= '0;
            overflow     <= 1'b0;
        end else if (adv) begin
            source_valid <= s2_valid;
            if (s2_valid) begin
                source_sop   <= s2_sop;
                source_eop   <= s2_eop;
                source_error <= s2_err;
                source_real  <= sat_re;
                source_imag  <= sat_im;
                overflow     <= (s2_sop ? 1'b0 : overflow) | clip_re | clip_im;
            end
        end
    end

endmodule

// File: tb/tb_idct_vecrot_pipe.sv
`timescale 1ns/1ps
// tb_idct_vecrot_pipe
// Directed bench for idct_vecrot_pipe. A registered ROM model answers
// coefficient reads. A monitor collects every output beat. Each beat is
// compared with hand-computed expectations queued by the stimulus task.
module tb_idct_vecrot_pipe;

    localparam int WDATAIN  = 24;
    localparam int WDATAOUT = 24;
    localparam int WCOEFF   = 18;
    localparam int SHIFT    = 16;
    localparam int WADDR    = 11;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sink_valid, sink_ready, sink_sop, sink_eop;
    logic [WDATAIN-1:0]  sink_real, sink_imag, sink_real_rev, sink_imag_rev;
    logic [11:0]         fftpts_in;
    logic                mode;
    logic [WADDR-1:0]    coeff_addr;
    logic                coeff_rd_en;
    logic [WCOEFF-1:0]   coeff_cos, coeff_sin;
    logic                source_valid, source_ready, source_sop, source_eop;
    logic [1:0]          source_error;
    logic [WDATAOUT-1:0] source_real, source_imag;
    logic [11:0]         fftpts_out;
    logic                overflow;

    always #5 clk = ~clk;

    idct_vecrot_pipe #(
        .WDATAIN(WDATAIN), .WDATAOUT(WDATAOUT), .WCOEFF(WCOEFF),
        .SHIFT(SHIFT), .WADDR(WADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag),
        .sink_real_rev(sink_real_rev), .sink_imag_rev(sink_imag_rev),
        .fftpts_in(fftpts_in), .mode(mode),
        .coeff_addr(coeff_addr), .coeff_rd_en(coeff_rd_en),
        .coeff_cos(coeff_cos), .coeff_sin(coeff_sin),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_error(source_error),
        .source_real(source_real), .source_imag(source_imag),
        .fftpts_out(fftpts_out), .overflow(overflow)
    );

    // Coefficient ROM model: data appears one clock after a read strobe.
    logic signed [WCOEFF-1:0] rom_cos [0:15];
    logic signed [WCOEFF-1:0] rom_sin [0:15];

    always @(posedge clk) begin
        if (coeff_rd_en) begin
            coeff_cos <= rom_cos[coeff_addr[3:0]];
            coeff_sin <= rom_sin[coeff_addr[3:0]];
        end
    end

    typedef struct {
        int re;
        int im;
        int err;
        int fl;
        int ovf;
        int cyc;
    } beat_t;

    beat_t expQ[$];
    beat_t obsQ[$];
    beat_t monBeat;
    int    cyc = 0;
    int    checkCount = 0;
    int    passCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: a beat transfers on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && source_valid && source_ready) begin
            monBeat.re  = int'($signed(source_real));
            monBeat.im  = int'($signed(source_imag));
            monBeat.err = int'(source_error);
            monBeat.fl  = int'(source_sop) * 2 + int'(source_eop);
            monBeat.ovf = int'(overflow);
            monBeat.cyc = cyc;
            obsQ.push_back(monBeat);
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed == expected)
            passCount++;
        else
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Present one beat, wait for it to be accepted, and queue its expected output.
    task automatic applyStimulus(input int ar, input int ai, input int br, input int bi,
                                 input bit sop, input bit eop,
                                 input int expRe, input int expIm, input int expErr, input int expOvf);
        beat_t e;
        int    waited;
        bit    done;
        waited        = 0;
        done          = 1'b0;
        sink_valid    = 1'b1;
        sink_sop      = sop;
        sink_eop      = eop;
        sink_real     = ar[WDATAIN-1:0];
        sink_imag     = ai[WDATAIN-1:0];
        sink_real_rev = br[WDATAIN-1:0];
        sink_imag_rev = bi[WDATAIN-1:0];
        e.re  = expRe;
        e.im  = expIm;
        e.err = expErr;
        e.fl  = int'(sop) * 2 + int'(eop);
        e.ovf = expOvf;
        e.cyc = 0;
        while (!done) begin
            @(negedge clk);
            if (sink_ready) begin
                e.cyc = cyc;
                expQ.push_back(e);
                done = 1'b1;
            end else if (waited >= 200) begin
                checkOutput("sink_accept", longint'(sink_ready), 1);
                done = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleInputs();
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    // Wait for all queued beats to emerge, then compare them one by one.
    task automatic checkFrame(input string tag, input bit checkLat);
        int waited;
        waited = 0;
        while (obsQ.size() < expQ.size() && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        repeat (6) @(posedge clk);
        #1;
        checkOutput({tag, "_count"}, obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput($sformatf("%s_re[%0d]", tag, i), obsQ[i].re, expQ[i].re);
            checkOutput($sformatf("%s_im[%0d]", tag, i), obsQ[i].im, expQ[i].im);
            checkOutput($sformatf("%s_err[%0d]", tag, i), obsQ[i].err, expQ[i].err);
            checkOutput($sformatf("%s_sopeop[%0d]", tag, i), obsQ[i].fl, expQ[i].fl);
            checkOutput($sformatf("%s_ovf[%0d]", tag, i), obsQ[i].ovf, expQ[i].ovf);
            if (checkLat)
                checkOutput($sformatf("%s_lat[%0d]", tag, i), obsQ[i].cyc - expQ[i].cyc, 3);
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic loadFramingRom();
        for (int i = 0; i < 16; i++) begin
            rom_cos[i] = 18'sd65536;
            rom_sin[i] = 18'(i * 4096);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        source_ready  = 1'b1;
        fftpts_in     = 12'd0;
        mode          = 1'b0;
        sink_real     = '0;
        sink_imag     = '0;
        sink_real_rev = '0;
        sink_imag_rev = '0;
        coeff_cos     = '0;
        coeff_sin     = '0;
        idleInputs();
        for (int i = 0; i < 16; i++) begin
            rom_cos[i] = 18'sd65536;
            rom_sin[i] = 18'sd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_valid", source_valid, 0);
        checkOutput("rst_real", source_real, 0);
        checkOutput("rst_error", source_error, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_fftpts", fftpts_out, 0);
        checkOutput("rst_rd_en", coeff_rd_en, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDCT frame, N = 8: DC term, B folding, pure-sine rotation, rounding
        rom_cos[2] = 18'sd0;
        rom_sin[2] = 18'sd65536;
        rom_cos[3] = 18'sd32769;
        fftpts_in  = 12'd8;
        mode       = 1'b0;
        applyStimulus(1000, -200, 77, 55, 1, 0, 1000, -200, 0, 0);
        applyStimulus(100, 0, 0, 50, 0, 0, 150, 0, 0, 0);
        applyStimulus(100, 0, 0, 0, 0, 0, 0, 100, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 4; k < 8; k++)
            applyStimulus(10 * k, -k, 0, 0, 0, k == 7, 10 * k, -k, 0, 0);
        idleInputs();
        checkFrame("idct", 1);
        checkOutput("fftpts_idct", fftpts_out, 8);

        // Same frame in DCT mode: only the sine term changes sign
        mode = 1'b1;
        applyStimulus(1000, -200, 77, 55, 1, 0, 1000, -200, 0, 0);
        applyStimulus(100, 0, 0, 50, 0, 0, 150, 0, 0, 0);
        applyStimulus(100, 0, 0, 0, 0, 0, 0, -100, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 4; k < 8; k++)
            applyStimulus(10 * k, -k, 0, 0, 0, k == 7, 10 * k, -k, 0, 0);
        idleInputs();
        checkFrame("dct", 1);
        mode = 1'b0;

        // Saturation in both directions with a sticky flag, then a clean N = 1 frame
        for (int i = 0; i < 16; i++) begin
            rom_cos[i] = 18'sd65536;
            rom_sin[i] = 18'sd0;
        end
        fftpts_in = 12'd4;
        applyStimulus(5, 5, 0, 0, 1, 0, 5, 5, 0, 0);
        applyStimulus(8388607, 0, 0, 8388607, 0, 0, 8388607, 0, 0, 1);
        applyStimulus(-8388608, 0, 0, -8388608, 0, 0, -8388608, 0, 0, 1);
        applyStimulus(7, 0, 0, 0, 0, 1, 7, 0, 0, 1);
        idleInputs();
        checkFrame("sat", 1);
        fftpts_in = 12'd1;
        applyStimulus(3, -4, 0, 0, 1, 1, 3, -4, 0, 0);
        idleInputs();
        checkFrame("n1", 1);

        // Backpressure: 16-beat frame with the output stalled for 5 clocks
        loadFramingRom();
        fftpts_in = 12'd16;
        fork
            begin
                for (int k = 0; k < 16; k++)
                    applyStimulus(16, 0, 0, 0, k == 0, k == 15, 16, k, 0, 0);
                idleInputs();
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                source_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_sink_ready", sink_ready, 0);
                    checkOutput("stall_rd_en", coeff_rd_en, 0);
                end
                @(posedge clk);
                #1;
                source_ready = 1'b1;
            end
        join
        checkFrame("stall", 0);
        checkOutput("fftpts_stall", fftpts_out, 16);

        // Early eop at k = 5
        fftpts_in = 12'd8;
        for (int k = 0; k < 6; k++)
            applyStimulus(16, 0, 0, 0, k == 0, k == 5, 16, k, (k == 5) ? 1 : 0, 0);
        idleInputs();
        checkFrame("early_eop", 1);

        // sop at k = 3 restarts numbering from 0
        for (int k = 0; k < 3; k++)
            applyStimulus(16, 0, 0, 0, k == 0, 0, 16, k, 0, 0);
        applyStimulus(16, 0, 0, 0, 1, 0, 16, 0, 2, 0);
        for (int k = 1; k < 8; k++)
            applyStimulus(16, 0, 0, 0, 0, k == 7, 16, k, 0, 0);
        idleInputs();
        checkFrame("mid_sop", 1);

        // Missing eop: error on k = 7 then wrap to k = 0, still inside the frame
        for (int k = 0; k < 9; k++)
            applyStimulus(16, 0, 0, 0, k == 0, 0, 16, k % 8, (k == 7) ? 1 : 0, 0);
        fftpts_in = 12'd1;
        applyStimulus(16, 0, 0, 0, 1, 1, 16, 0, 2, 0);
        applyStimulus(16, 0, 0, 0, 0, 0, 16, 0, 2, 0);
        idleInputs();
        checkFrame("no_eop", 1);

        // Asynchronous reset during beat 4 of a frame
        fftpts_in = 12'd8;
        for (int k = 0; k < 4; k++)
            applyStimulus(16, 0, 0, 0, k == 0, 0, 16, k, 0, 0);
        sink_valid = 1'b1;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", source_valid, 0);
        checkOutput("midrst_real", source_real, 0);
        checkOutput("midrst_imag", source_imag, 0);
        checkOutput("midrst_error", source_error, 0);
        checkOutput("midrst_fftpts", fftpts_out, 0);
        checkOutput("midrst_overflow", overflow, 0);
        idleInputs();
        repeat (2) @(posedge clk);
        expQ.delete();
        obsQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fftpts_in = 12'd2;
        applyStimulus(16, 0, 0, 0, 1, 0, 16, 0, 0, 0);
        applyStimulus(16, 0, 0, 0, 0, 1, 16, 1, 0, 0);
        idleInputs();
        checkFrame("post_rst", 1);
        checkOutput("post_rst_fftpts", fftpts_out, 2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
